vpu_ub_writer: RTL and testbench
================================

VPU_UB_WRITER -- requirements
Module: vpu_ub_writer

Interface
REQ-001 SHALL have clk input 1: clock; all state changes on rising edge.
REQ-002 SHALL have rst input 1: reset, asynchronous, active-high.
REQ-003 SHALL have start input 1: single-cycle pulse that begins a writeback job.
REQ-004 SHALL have base_addr input 16: UB row address of the first write; sampled on accepted start.
REQ-005 SHALL have num_rows input 8: rows in the job; sampled on accepted start.
REQ-006 SHALL have vpu_data_in_1 and vpu_data_in_2 inputs, signed 16 each: VPU lane outputs.
REQ-007 SHALL have vpu_valid_in_1 and vpu_valid_in_2 inputs, 1 each: lane qualifiers; lane 2 nominally lags lane 1 by one cycle.
REQ-008 SHALL have ub_wr_ready input 1: UB accepts the presented write this cycle.
REQ-009 SHALL have ub_wr_en output 1: write valid.
REQ-010 SHALL have ub_wr_addr output 16: write row address.
REQ-011 SHALL have ub_wr_data_1 and ub_wr_data_2 outputs, signed 16 each: lane values for the row.
REQ-012 SHALL have busy output 1: job in progress.
REQ-013 SHALL have done output 1: one-cycle job-complete pulse.
REQ-014 SHALL have overflow output 1: sticky lane-FIFO overflow flag.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on final accepted write; DONE->IDLE unconditionally after 1 cycle.
REQ-016 SHALL go IDLE->DONE directly on start when num_rows==0, with no writes.
REQ-017 SHALL ignore start in RUN or DONE.
REQ-018 SHALL assert busy in RUN only, and done for the single DONE cycle.
REQ-019 SHALL push each lane into its own 4-entry FIFO when that lane's valid is high in RUN; valids in IDLE/DONE are dropped without setting overflow.
REQ-020 SHALL drop a push into a full FIFO and set overflow, unless a pop occurs in the same cycle, in which case the push succeeds.
REQ-021 SHALL make an entry pushed at edge E poppable no earlier than the cycle after E.
REQ-022 SHALL pop both FIFOs together into a registered output stage only when both are non-empty and the output stage is empty or being accepted.
REQ-023 SHALL hold ub_wr_en, ub_wr_addr and data stable until the cycle ub_wr_en and ub_wr_ready are both high.
REQ-024 SHALL use ub_wr_addr = base_addr + row_index, with row_index 0..num_rows-1 and 16-bit wrap-around (0xFFFF+1 -> 0x0000).
REQ-025 SHALL, with ub_wr_ready held high, raise ub_wr_en in the cycle after the edge E+1, where E is the edge sampling the later lane's valid (2-cycle latency).
REQ-026 SHALL sustain one row per cycle under continuous input and ready.
REQ-027 SHALL stop popping after num_rows writes; surplus FIFO entries are flushed on DONE.
REQ-028 SHALL clear overflow only on reset or on an accepted start.

Reset
REQ-029 SHALL on rst force state IDLE, empty both FIFOs, row_index 0, and outputs ub_wr_en 0, ub_wr_addr 0, ub_wr_data_1/2 0, busy 0, done 0, overflow 0.
REQ-030 SHALL abandon any in-flight job when rst asserts mid-operation, with no write issued after rst deasserts until a new start.

Structure
REQ-031 SHALL take DATA_W=16, ADDR_W=16, ROWS_W=8, FIFO_DEPTH=4 and the FSM state enum from shared package vpu_wb_pkg.
REQ-032 SHALL instantiate sub-module lane_fifo twice: a 4-deep synchronous FIFO with async reset and full/empty flags.

Verification
REQ-033 SHALL cover nominal skew: base 0x0010, rows 3, lane1 {1,2,3} on cycles 1-3, lane2 {-1,-2,-3} on cycles 2-4, ready=1 -> writes (0x0010,1,-1), (0x0011,2,-2), (0x0012,3,-3), then done 1 cycle, overflow 0.
REQ-034 SHALL cover backpressure: ready=0 for 5 cycles during the above -> first write held stable with identical address/data, no loss, order preserved.
REQ-035 SHALL cover overflow: ready=0, 6 lane-1 samples pushed -> overflow=1 after the 5th push, first 4 values written once ready=1.
REQ-036 SHALL cover num_rows=0: start -> done next cycle, no ub_wr_en, busy never high.
REQ-037 SHALL cover address wrap: base 0xFFFF, rows 2 -> addresses 0xFFFF then 0x0000.
REQ-038 SHALL cover reset mid-job: rst after 1 of 3 writes -> all outputs 0 and no further writes until the next start.

Source files
------------

// File: rtl/vpu_wb_pkg.sv
// Shared widths and FSM encoding for the VPU-to-unified-buffer writeback path.
package vpu_wb_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int ROWS_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/lane_fifo.sv
// Small synchronous FIFO for one VPU lane; a push into a full FIFO is dropped
// and reported unless a pop frees a slot in the same cycle.
module lane_fifo
    import vpu_wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           count_q, count_d;
    logic                     do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vpu_ub_writer.sv
// Pairs the two VPU lane streams row by row and writes them to the unified
// buffer at consecutive addresses through a ready/valid output register.
module vpu_ub_writer
    import vpu_wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ROWS_W-1:0]        num_rows,
    input  logic signed [DATA_W-1:0] vpu_data_in_1,
    input  logic signed [DATA_W-1:0] vpu_data_in_2,
    input  logic                     vpu_valid_in_1,
    input  logic                     vpu_valid_in_2,
    input  logic                     ub_wr_ready,
    output logic                     ub_wr_en,
    output logic [ADDR_W-1:0]        ub_wr_addr,
    output logic signed [DATA_W-1:0] ub_wr_data_1,
    output logic signed [DATA_W-1:0] ub_wr_data_2,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    wb_state_e                state_q, state_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ROWS_W-1:0]        rows_q, rows_d;
    logic [ROWS_W-1:0]        pop_cnt_q, pop_cnt_d;
    logic [ROWS_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic                     out_vld_q, out_vld_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic signed [DATA_W-1:0] d1_q, d1_d;
    logic signed [DATA_W-1:0] d2_q, d2_d;
    logic                     ovf_q, ovf_d;

    logic                     run, flush, accept, pop;
    logic                     push_1, push_2;
    logic signed [DATA_W-1:0] rdata_1, rdata_2;
    logic                     full_1, full_2, empty_1, empty_2, drop_1, drop_2;

    assign run    = (state_q == ST_RUN);
    assign flush  = (state_q == ST_DONE);
    assign accept = out_vld_q && ub_wr_ready;
    assign push_1 = run && vpu_valid_in_1;
    assign push_2 = run && vpu_valid_in_2;
    // Rows leave only as complete pairs, and never beyond the job length.
    assign pop    = run && !empty_1 && !empty_2 && (!out_vld_q || accept)
                    && (pop_cnt_q != rows_q);

    lane_fifo u_fifo_1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_1),
        .pop   (pop),
        .wdata (vpu_data_in_1),
        .rdata (rdata_1),
        .full  (full_1),
        .empty (empty_1),
        .drop  (drop_1)
    );

    lane_fifo u_fifo_2 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_2),
        .pop   (pop),
        .wdata (vpu_data_in_2),
        .rdata (rdata_2),
        .full  (full_2),
        .empty (empty_2),
        .drop  (drop_2)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        rows_d    = rows_q;
        pop_cnt_d = pop_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        out_vld_d = out_vld_q;
        addr_d    = addr_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        ovf_d     = ovf_q || drop_1 || drop_2;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    rows_d    = num_rows;
                    pop_cnt_d = '0;
                    wr_cnt_d  = '0;
                    ovf_d     = 1'b0;
                    state_d   = (num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == rows_q - 1'b1) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            out_vld_d = 1'b1;
            addr_d    = base_q + ADDR_W'(pop_cnt_q);
            d1_d      = rdata_1;
            d2_d      = rdata_2;
            pop_cnt_d = pop_cnt_q + 1'b1;
        end else if (accept) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            pop_cnt_q <= '0;
            wr_cnt_q  <= '0;
            out_vld_q <= 1'b0;
            addr_q    <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rows_q    <= rows_d;
            pop_cnt_q <= pop_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            out_vld_q <= out_vld_d;
            addr_q    <= addr_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ub_wr_en     = out_vld_q;
    assign ub_wr_addr   = addr_q;
    assign ub_wr_data_1 = d1_q;
    assign ub_wr_data_2 = d2_q;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_vpu_ub_writer.sv
// Bench for vpu_ub_writer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized jobs.
module tb_vpu_ub_writer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [15:0]        base_addr = '0;
    logic [7:0]         num_rows = '0;
    logic signed [15:0] vpu_data_in_1 = '0;
    logic signed [15:0] vpu_data_in_2 = '0;
    logic               vpu_valid_in_1 = 1'b0;
    logic               vpu_valid_in_2 = 1'b0;
    logic               ub_wr_ready = 1'b0;
    logic               ub_wr_en;
    logic [15:0]        ub_wr_addr;
    logic signed [15:0] ub_wr_data_1;
    logic signed [15:0] ub_wr_data_2;
    logic               busy, done, overflow;

    always #5 clk = ~clk;

    vpu_ub_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .num_rows       (num_rows),
        .vpu_data_in_1  (vpu_data_in_1),
        .vpu_data_in_2  (vpu_data_in_2),
        .vpu_valid_in_1 (vpu_valid_in_1),
        .vpu_valid_in_2 (vpu_valid_in_2),
        .ub_wr_ready    (ub_wr_ready),
        .ub_wr_en       (ub_wr_en),
        .ub_wr_addr     (ub_wr_addr),
        .ub_wr_data_1   (ub_wr_data_1),
        .ub_wr_data_2   (ub_wr_data_2),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: job phase, two lane queues and the presented write.
    int                 m_phase = 0;   // 0 idle, 1 running, 2 done pulse
    logic [15:0]        m_base = '0;
    int                 m_rows = 0;
    int                 m_popped = 0;
    int                 m_written = 0;
    logic signed [15:0] q1[$];
    logic signed [15:0] q2[$];
    bit                 m_wr_en = 0;
    logic [15:0]        m_addr = '0;
    logic signed [15:0] m_d1 = '0;
    logic signed [15:0] m_d2 = '0;
    bit                 m_ovf = 0;

    always @(posedge clk or posedge rst) begin : model
        bit acc, pop_ok;
        if (rst) begin
            m_phase = 0; m_base = '0; m_rows = 0; m_popped = 0; m_written = 0;
            q1.delete(); q2.delete();
            m_wr_en = 0; m_addr = '0; m_d1 = '0; m_d2 = '0; m_ovf = 0;
        end else begin
            acc = m_wr_en && ub_wr_ready;
            case (m_phase)
                0: if (start) begin
                    m_base = base_addr; m_rows = int'(num_rows);
                    m_popped = 0; m_written = 0; m_ovf = 0;
                    m_phase = (num_rows == 0) ? 2 : 1;
                end
                1: begin
                    pop_ok = q1.size() > 0 && q2.size() > 0 && (!m_wr_en || acc)
                             && m_popped < m_rows;
                    if (pop_ok) begin
                        m_addr  = m_base + 16'(m_popped);
                        m_d1    = q1.pop_front();
                        m_d2    = q2.pop_front();
                        m_wr_en = 1;
                        m_popped++;
                    end else if (acc) begin
                        m_wr_en = 0;
                    end
                    if (vpu_valid_in_1) begin
                        if (q1.size() < 4) q1.push_back(vpu_data_in_1); else m_ovf = 1;
                    end
                    if (vpu_valid_in_2) begin
                        if (q2.size() < 4) q2.push_back(vpu_data_in_2); else m_ovf = 1;
                    end
                    if (acc) begin
                        m_written++;
                        if (m_written == m_rows) m_phase = 2;
                    end
                end
                default: begin
                    q1.delete(); q2.delete();
                    m_phase = 0;
                end
            endcase
        end
    end

    typedef struct {
        logic [15:0]        a;
        logic signed [15:0] d1;
        logic signed [15:0] d2;
    } wr_t;
    wr_t wr_log[$];
    int  done_cnt = 0;

    // Per-cycle compare plus a log of accepted writes (ready is stable here).
    always @(negedge clk) begin
        check("wr_en",    32'(ub_wr_en), 32'(m_wr_en));
        check("wr_addr",  32'(ub_wr_addr), 32'(m_addr));
        check("wr_data1", 32'(ub_wr_data_1), 32'(m_d1));
        check("wr_data2", 32'(ub_wr_data_2), 32'(m_d2));
        check("busy",     32'(busy), 32'(m_phase == 1));
        check("done",     32'(done), 32'(m_phase == 2));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (!rst && ub_wr_en && ub_wr_ready) wr_log.push_back('{ub_wr_addr, ub_wr_data_1, ub_wr_data_2});
        if (!rst && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; vpu_valid_in_1 = 0; vpu_valid_in_2 = 0;
    endtask

    task automatic kick(input logic [15:0] b, input logic [7:0] r);
        start = 1; base_addr = b; num_rows = r;
        tick();
        start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        quiet();
        ub_wr_ready = 1;
        while ((busy || done) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(busy || done), 32'(0));
        tick();
    endtask

    task automatic check_log(input string name, input int idx, input logic [15:0] a,
                             input logic signed [15:0] x, input logic signed [15:0] y);
        if (idx >= wr_log.size()) begin
            check({name, "_missing"}, 32'(wr_log.size()), 32'(idx + 1));
        end else begin
            check({name, "_addr"}, 32'(wr_log[idx].a), 32'(a));
            check({name, "_d1"},   32'(wr_log[idx].d1), 32'(x));
            check({name, "_d2"},   32'(wr_log[idx].d2), 32'(y));
        end
    endtask

    task automatic nominal(input bit bp, input string tag);
        int d0;
        wr_log.delete();
        d0 = done_cnt;
        ub_wr_ready = 1;
        kick(16'h0010, 8'd3);
        check({tag, "_ovf_start"}, 32'(overflow), 32'(0));
        for (int k = 0; k < 8; k++) begin
            vpu_valid_in_1 = (k < 3);
            vpu_data_in_1  = 16'(k + 1);
            vpu_valid_in_2 = (k >= 1 && k <= 3);
            vpu_data_in_2  = -16'(k);
            ub_wr_ready    = !(bp && k >= 1 && k <= 5);
            tick();
        end
        wait_idle(tag);
        check({tag, "_nwr"}, 32'(wr_log.size()), 32'(3));
        check_log({tag, "_w0"}, 0, 16'h0010, 16'sd1, -16'sd1);
        check_log({tag, "_w1"}, 1, 16'h0011, 16'sd2, -16'sd2);
        check_log({tag, "_w2"}, 2, 16'h0012, 16'sd3, -16'sd3);
        check({tag, "_done1"}, 32'(done_cnt - d0), 32'(1));
        check({tag, "_ovf"}, 32'(overflow), 32'(0));
    endtask

    initial begin
        #1;
        check("rst_wr_en", 32'(ub_wr_en), 32'(0));
        check("rst_busy",  32'(busy), 32'(0));
        check("rst_ovf",   32'(overflow), 32'(0));
        tick(); tick();
        rst = 0;
        tick();

        nominal(1'b0, "nom");
        nominal(1'b1, "bp");

        // Lane 1 alone fills its FIFO with ready low; the fifth push overflows.
        wr_log.delete();
        ub_wr_ready = 0;
        kick(16'h0100, 8'd4);
        for (int k = 0; k < 6; k++) begin
            vpu_valid_in_1 = 1; vpu_data_in_1 = 16'(10 + k);
            tick();
            if (k == 3) check("ovf_after4", 32'(overflow), 32'(0));
            if (k == 4) check("ovf_after5", 32'(overflow), 32'(1));
        end
        vpu_valid_in_1 = 0;
        for (int k = 0; k < 4; k++) begin
            vpu_valid_in_2 = 1; vpu_data_in_2 = -16'(10 + k);
            tick();
        end
        wait_idle("ovf");
        check("ovf_nwr", 32'(wr_log.size()), 32'(4));
        for (int k = 0; k < 4; k++)
            check_log($sformatf("ovf_w%0d", k), k, 16'h0100 + 16'(k), 16'(10 + k), -16'(10 + k));
        check("ovf_sticky", 32'(overflow), 32'(1));

        // Zero-row job: done on the next cycle, no write, overflow cleared by start.
        wr_log.delete();
        kick(16'h0abc, 8'd0);
        check("z_done", 32'(done), 32'(1));
        check("z_busy", 32'(busy), 32'(0));
        check("z_ovf",  32'(overflow), 32'(0));
        tick();
        check("z_done_low", 32'(done), 32'(0));
        check("z_nwr", 32'(wr_log.size()), 32'(0));

        // Address wrap.
        wr_log.delete();
        ub_wr_ready = 1;
        kick(16'hffff, 8'd2);
        for (int k = 0; k < 2; k++) begin
            vpu_valid_in_1 = 1; vpu_data_in_1 = 16'(7 + k);
            vpu_valid_in_2 = 1; vpu_data_in_2 = -16'(7 + k);
            tick();
        end
        wait_idle("wrap");
        check_log("wrap_w0", 0, 16'hffff, 16'sd7, -16'sd7);
        check_log("wrap_w1", 1, 16'h0000, 16'sd8, -16'sd8);

        // Reset after the first of three writes.
        begin
            int n = 0;
            wr_log.delete();
            ub_wr_ready = 1;
            kick(16'h0020, 8'd3);
            vpu_valid_in_1 = 1; vpu_valid_in_2 = 1;
            while (wr_log.size() < 1 && n < 50) begin
                vpu_data_in_1 = 16'(n + 40); vpu_data_in_2 = 16'(n + 50);
                tick();
                n++;
            end
            check("rstm_first", 32'(wr_log.size()), 32'(1));
            #1 rst = 1;
            #1;
            check("rstm_wr_en", 32'(ub_wr_en), 32'(0));
            check("rstm_addr",  32'(ub_wr_addr), 32'(0));
            check("rstm_d1",    32'(ub_wr_data_1), 32'(0));
            check("rstm_d2",    32'(ub_wr_data_2), 32'(0));
            check("rstm_busy",  32'(busy), 32'(0));
            tick();
            rst = 0;
            for (int k = 0; k < 6; k++) tick();
            quiet();
            tick();
            check("rstm_nwr", 32'(wr_log.size()), 32'(1));
        end

        // Randomized jobs with skewed valids, random backpressure and stray starts.
        for (int j = 0; j < 25; j++) begin
            int rows, n;
            rows = $urandom_range(0, 12);
            wr_log.delete();
            kick(16'($urandom), 8'(rows));
            n = 0;
            while ((busy || done) && n < 600) begin
                vpu_valid_in_1 = ($urandom_range(0, 9) < 6);
                vpu_valid_in_2 = ($urandom_range(0, 9) < 6);
                vpu_data_in_1  = 16'($urandom);
                vpu_data_in_2  = 16'($urandom);
                ub_wr_ready    = ($urandom_range(0, 9) < 7);
                start          = ($urandom_range(0, 19) == 0);
                base_addr      = 16'($urandom);
                num_rows       = 8'($urandom);
                tick();
                n++;
            end
            quiet();
            check($sformatf("rnd%0d_timeout", j), 32'(busy || done), 32'(0));
            check($sformatf("rnd%0d_nwr", j), 32'(wr_log.size()), 32'(rows));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
